// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB     = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure combinational decode of the current state into the datapath control word.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Moore decode; only FETCH looks at mem_ready to latch IR and bump PC
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SEXT_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, retire counter.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             illegalOp,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q;
  state_t           state_d;
  ctrl_t            ctrl;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  logic             unused_zero;

  // The branch decision is made in the datapath from PCWriteCond & zero
  assign unused_zero = zero;

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; stalls hold the state while memory is busy
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADDR:  state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = memReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = memReady ? S_FETCH : S_MEMWRITE;
      S_EXEC:     state_d = S_RWB;
      S_RWB:      state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires when its final state hands back to FETCH
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWRITE, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (memReady),
    .ctrl      (ctrl)
  );

  // Side-effecting strobes are gated off while reset is held
  assign PCWrite     = ctrl.pc_write      & rst_n;
  assign PCWriteCond = ctrl.pc_write_cond & rst_n;
  assign MemRead     = ctrl.mem_read      & rst_n;
  assign MemWrite    = ctrl.mem_write     & rst_n;
  assign IRWrite     = ctrl.ir_write      & rst_n;
  assign RegWrite    = ctrl.reg_write     & rst_n;
  assign IorD        = ctrl.ior_d;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegDst      = ctrl.reg_dst;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign illegalOp   = rst_n & (state_q == S_DECODE) & ~is_legal_op(opcode);
  assign state       = state_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl with a 4-bit retire counter.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       memReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegalOp;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] state;
  logic [3:0] retired;

  int checks = 0;
  int failures = 0;
  int model_ret = 0;

  typedef struct {
    int st;
    bit mr;
  } step_t;

  step_t seq[$];

  logic [16:0] ctrl_vec;
  assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB,
                     PCSource, illegalOp};

  localparam logic [16:0] RESET_VEC = 17'h00008;

  mips_multicycle_ctrl #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .zero        (zero),
    .memReady    (memReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .illegalOp   (illegalOp),
    .state       (state),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B ||
           op == 6'h04 || op == 6'h02 || op == 6'h08;
  endfunction

  // Expected control word for a state, following the state-by-state output table
  function automatic logic [16:0] exp_vec(input int st, input bit mr, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill;
    logic [1:0] aop, bsrc, psrc;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill} = '0;
    aop = 2'b00; bsrc = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mrd = 1; bsrc = 2'b01; irw = mr; pcw = mr; end
      1:  begin bsrc = 2'b11; ill = !legal(op); end
      2:  begin asa = 1; bsrc = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin asa = 1; bsrc = 2'b10; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, aop, bsrc, psrc, ill};
  endfunction

  task automatic push_wait(input int st, input int stalls);
    for (int i = 0; i < stalls; i++) seq.push_back('{st, 1'b0});
    seq.push_back('{st, 1'b1});
  endtask

  task automatic push_one(input int st);
    seq.push_back('{st, 1'($urandom)});
  endtask

  // Build the state walk an instruction takes from its opcode and stall counts
  task automatic build_seq(input logic [5:0] op, input int fs, input int ms);
    seq.delete();
    push_wait(0, fs);
    push_one(1);
    case (op)
      6'h23: begin push_one(2); push_wait(3, ms); push_one(4); end
      6'h2B: begin push_one(2); push_wait(5, ms); end
      6'h00: begin push_one(6); push_one(7); end
      6'h04: push_one(8);
      6'h02: push_one(9);
      6'h08: begin push_one(10); push_one(11); end
      default: ;
    endcase
  endtask

  task automatic checkOutput(input int st, input bit mr, input logic [5:0] op, input string tag);
    logic [16:0] e;
    e = exp_vec(st, mr, op);
    checks++;
    assert (state === 4'(st)) else begin
      failures++;
      $error("[TB] FAIL %s state got=%0d exp=%0d", tag, state, st);
    end
    checks++;
    assert (ctrl_vec === e) else begin
      failures++;
      $error("[TB] FAIL %s ctrl st=%0d got=%05h exp=%05h", tag, st, ctrl_vec, e);
    end
  endtask

  task automatic exec_seq(input logic [5:0] op, input string tag);
    foreach (seq[i]) begin
      memReady = seq[i].mr;
      @(negedge clk);
      checkOutput(seq[i].st, seq[i].mr, op, tag);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input int fs, input int ms,
                               input bit z, input string tag);
    opcode = op;
    zero   = z;
    build_seq(op, fs, ms);
    exec_seq(op, tag);
    if (legal(op)) model_ret = (model_ret + 1) % 16;
    checks++;
    assert (retired === 4'(model_ret)) else begin
      failures++;
      $error("[TB] FAIL %s retired got=%0d exp=%0d", tag, retired, model_ret);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    assert (state === 4'd0 && retired === 4'd0) else begin
      failures++;
      $error("[TB] FAIL %s reset state/retired got=%0d/%0d exp=0/0", tag, state, retired);
    end
    checks++;
    assert (ctrl_vec === RESET_VEC) else begin
      failures++;
      $error("[TB] FAIL %s reset ctrl got=%05h exp=%05h", tag, ctrl_vec, RESET_VEC);
    end
  endtask

  logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

  initial begin
    rst_n    = 1'b0;
    opcode   = 6'h00;
    zero     = 1'b0;
    memReady = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_state("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type with no stalls, then lw with three MEMREAD stalls
    applyStimulus(6'h00, 0, 0, 1'b0, "rtype");
    applyStimulus(6'h23, 0, 3, 1'b0, "lw_stall");
    applyStimulus(6'h23, 2, 0, 1'b1, "lw_fstall");
    applyStimulus(6'h2B, 1, 2, 1'b0, "sw_stall");
    applyStimulus(6'h08, 0, 0, 1'b0, "addi");

    // Branch taken and not taken both retire
    applyStimulus(6'h04, 0, 0, 1'b1, "beq_z1");
    applyStimulus(6'h04, 0, 0, 1'b0, "beq_z0");

    // Illegal opcode goes straight back to FETCH without retiring
    applyStimulus(6'h3F, 0, 0, 1'b0, "illegal");

    // Reset during a stalled store aborts it asynchronously
    opcode = 6'h2B;
    seq.delete();
    push_wait(0, 0);
    push_one(1);
    push_one(2);
    exec_seq(6'h2B, "sw_abort");
    memReady = 1'b0;
    #2;
    checks++;
    assert (state === 4'd5 && MemWrite === 1'b1) else begin
      failures++;
      $error("[TB] FAIL sw_wait state/MemWrite got=%0d/%0b exp=5/1", state, MemWrite);
    end
    rst_n = 1'b0;
    #1;
    model_ret = 0;
    check_reset_state("async_rst");
    memReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("held_rst");
    rst_n = 1'b1;

    // Sixteen jumps wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) applyStimulus(6'h02, 0, 0, 1'b0, "jwrap");
    checks++;
    assert (retired === 4'd0) else begin
      failures++;
      $error("[TB] FAIL wrap retired got=%0d exp=0", retired);
    end

    // Random instruction mix with random memory stalls
    for (int n = 0; n < 150; n++) begin
      int r;
      logic [5:0] op;
      r = $urandom_range(0, 6);
      op = (r < 6) ? legal_ops[r] : 6'($urandom);
      applyStimulus(op, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
